// File: rtl/id_ex_buf_if.sv
// Decode-to-execute stage bus: the decode bundle with its valid/ready pair,
// the flush request from ex, and the registered bundle presented to ex.
interface id_ex_buf_if;
  // decode side
  logic        id_valid;
  logic        id_ready;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] ins2ex;
  logic [31:0] ins_addr;
  logic [4:0]  rd_addr;
  logic        rd_wen;
  logic [6:0]  oh;
  // squash request from ex (taken branch/jump)
  logic        flush;
  // execute side
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_ins;
  logic [31:0] ex_ins_addr;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_wen;
  logic [6:0]  ex_oh;

  // the pipeline buffer itself
  modport slave (
    input  id_valid, op1, op2, ins2ex, ins_addr, rd_addr, rd_wen, oh,
    input  flush, ex_ready,
    output id_ready,
    output ex_valid, ex_op1, ex_op2, ex_ins, ex_ins_addr, ex_rd_addr, ex_rd_wen, ex_oh
  );

  // the surrounding stages (decode drives, execute consumes)
  modport master (
    output id_valid, op1, op2, ins2ex, ins_addr, rd_addr, rd_wen, oh,
    output flush, ex_ready,
    input  id_ready,
    input  ex_valid, ex_op1, ex_op2, ex_ins, ex_ins_addr, ex_rd_addr, ex_rd_wen, ex_oh
  );
endinterface

// File: rtl/id_ex_buf.sv
// ID/EX pipeline buffer: two-entry skid buffer (MAIN drives ex, SKID catches
// the bundle accepted while ex stalls) so id_ready comes straight from a flop.
// A taken branch/jump from ex squashes everything held and arriving; with
// nothing valid, ex sees an ADDI x0,x0,0 bubble that never writes back.
module id_ex_buf (
  input  logic        clk,
  input  logic        rst,
  id_ex_buf_if.slave  bus
);

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] ins;
    logic [31:0] ins_addr;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic [6:0]  oh;
  } payload_t;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  payload_t   in_pl, main_q, skid_q;
  logic [1:0] state_q, state_d;
  logic       id_ready_q;
  logic       ex_valid;
  logic       in_fire, out_fire;
  logic       load_main, main_from_skid, load_skid;

  assign in_pl = '{op1: bus.op1, op2: bus.op2, ins: bus.ins2ex, ins_addr: bus.ins_addr,
                   rd_addr: bus.rd_addr, rd_wen: bus.rd_wen, oh: bus.oh};

  // valid is a pure decode of the state flop, so no input reaches ex_* combinationally
  assign ex_valid = (state_q != EMPTY);
  assign in_fire  = bus.id_valid & id_ready_q;
  assign out_fire = ex_valid & bus.ex_ready;

  // next state and which entry loads; flush wins over both handshakes
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (in_fire) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
        ONE: case ({in_fire, out_fire})
          2'b11:   load_main = 1'b1;
          2'b01:   state_d   = EMPTY;
          2'b10: begin
            state_d   = FULL;
            load_skid = 1'b1;
          end
          default: ;
        endcase
        FULL: if (out_fire) begin
          // id_ready was low, so nothing new can arrive in this state
          state_d        = ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // state, registered ready and payload storage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      id_ready_q <= 1'b1;
      main_q     <= '0;
    end else begin
      state_q    <= state_d;
      id_ready_q <= (state_d != FULL);
      if (load_main) main_q <= main_from_skid ? skid_q : in_pl;
    end
  end

  // SKID is don't-care while unused, so it needs no reset
  always_ff @(posedge clk) begin
    if (load_skid) skid_q <= in_pl;
  end

  assign bus.id_ready    = id_ready_q;
  assign bus.ex_valid    = ex_valid;
  assign bus.ex_op1      = ex_valid ? main_q.op1      : 32'd0;
  assign bus.ex_op2      = ex_valid ? main_q.op2      : 32'd0;
  assign bus.ex_ins      = ex_valid ? main_q.ins      : NOP_INS;
  assign bus.ex_ins_addr = ex_valid ? main_q.ins_addr : 32'd0;
  assign bus.ex_rd_addr  = ex_valid ? main_q.rd_addr  : 5'd0;
  assign bus.ex_rd_wen   = ex_valid & main_q.rd_wen;
  assign bus.ex_oh       = ex_valid ? main_q.oh       : 7'd0;

endmodule
